// File: rtl/paridad_serial_arbitrada_pkg.sv
// ============================================================================
// paridad_serial_arbitrada_pkg: shared FSM encoding, requester count, helper
// Rev 1.0
// ============================================================================
`default_nettype none

package paridad_serial_arbitrada_pkg;

  localparam int c_num_sol = 2;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    CALCULO = 2'd1,
    FIN     = 2'd2
  } estado_t;

  function automatic logic xor_par(input logic [1:0] par);
    return par[1] ^ par[0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/paridad_serial_arbitrada_if.sv
// ============================================================================
// paridad_serial_arbitrada_if: request/data/result bundle of the parity engine
// Rev 1.0
// ============================================================================
`default_nettype none

interface paridad_serial_arbitrada_if #(
  parameter int ANCHO = 8
);
  import paridad_serial_arbitrada_pkg::*;

  logic [c_num_sol-1:0] Solicitud;
  logic [ANCHO-1:0]     Dato0;
  logic [ANCHO-1:0]     Dato1;
  logic [c_num_sol-1:0] Concedido;
  logic                 Ocupado;
  logic                 Listo;
  logic                 Paridad;
  logic                 Origen;

  modport master (
    output Solicitud, Dato0, Dato1,
    input  Concedido, Ocupado, Listo, Paridad, Origen
  );

  modport slave (
    input  Solicitud, Dato0, Dato1,
    output Concedido, Ocupado, Listo, Paridad, Origen
  );

endinterface

`default_nettype wire

// File: rtl/paridad_serial_arbitrada_arbitro_rr.sv
// ============================================================================
// arbitro_rr: two-requester round-robin arbiter with a 1-bit priority pointer
// Rev 1.0
// ============================================================================
`default_nettype none

module arbitro_rr
  import paridad_serial_arbitrada_pkg::*;
(
  input  wire logic                 Reloj,
  input  wire logic                 Reinicio,
  input  wire logic                 habilitar_i,
  input  wire logic [c_num_sol-1:0] solicitud_i,
  output logic      [c_num_sol-1:0] concedido_o,
  output logic                      indice_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    concedido_o = '0;
    indice_o    = 1'b0;
    if (habilitar_i) begin
      unique case (solicitud_i)
        2'b01: begin
          concedido_o = 2'b01;
          indice_o    = 1'b0;
        end
        2'b10: begin
          concedido_o = 2'b10;
          indice_o    = 1'b1;
        end
        2'b11: begin
          concedido_o = ptr_q ? 2'b10 : 2'b01;
          indice_o    = ptr_q;
        end
        default: ;
      endcase
    end
    // Priority passes to the requester that lost (or did not ask) this time.
    ptr_d = ptr_q;
    if (|concedido_o) begin
      ptr_d = ~indice_o;
    end
  end

  always_ff @(posedge Reloj) begin
    if (Reinicio) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/paridad_serial_arbitrada.sv
// ============================================================================
// paridad_serial_arbitrada: arbitrated serial parity, two bits per cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module paridad_serial_arbitrada #(
  parameter int ANCHO = 8
) (
  input wire logic                   Reloj,
  input wire logic                   Reinicio,
  paridad_serial_arbitrada_if.slave  bus
);
  import paridad_serial_arbitrada_pkg::*;

  // ANCHO must be even and >= 2: the datapath consumes one bit pair per cycle.
  localparam int unsigned c_pasos     = ANCHO / 2;
  localparam int unsigned c_ancho_cnt = (c_pasos > 1) ? $clog2(c_pasos) : 1;
  localparam logic [c_ancho_cnt-1:0] c_ultimo = c_ancho_cnt'(c_pasos - 1);

  estado_t                estado_q, estado_d;
  logic [ANCHO-1:0]       desp_q, desp_d;
  logic                   acc_q, acc_d;
  logic [c_ancho_cnt-1:0] cnt_q, cnt_d;
  logic                   sel_q, sel_d;
  logic                   paridad_q, paridad_d;
  logic                   origen_q, origen_d;

  logic [c_num_sol-1:0]   concedido;
  logic                   indice;
  logic                   habilitar;

  assign habilitar = (estado_q == REPOSO) && !Reinicio;

  arbitro_rr u_arbitro (
    .Reloj       (Reloj),
    .Reinicio    (Reinicio),
    .habilitar_i (habilitar),
    .solicitud_i (bus.Solicitud),
    .concedido_o (concedido),
    .indice_o    (indice)
  );

  always_comb begin
    estado_d  = estado_q;
    desp_d    = desp_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    paridad_d = paridad_q;
    origen_d  = origen_q;
    unique case (estado_q)
      REPOSO: begin
        if (|concedido) begin
          desp_d   = indice ? bus.Dato1 : bus.Dato0;
          acc_d    = 1'b0;
          cnt_d    = '0;
          sel_d    = indice;
          estado_d = CALCULO;
        end
      end
      CALCULO: begin
        acc_d  = acc_q ^ xor_par(desp_q[1:0]);
        desp_d = desp_q >> 2;
        cnt_d  = cnt_q + 1'b1;
        // Result registers load on the last step so they are visible in FIN.
        if (cnt_q == c_ultimo) begin
          paridad_d = acc_d;
          origen_d  = sel_q;
          estado_d  = FIN;
        end
      end
      FIN: begin
        estado_d = REPOSO;
      end
      default: begin
        estado_d = REPOSO;
      end
    endcase
  end

  always_ff @(posedge Reloj) begin
    if (Reinicio) begin
      estado_q  <= REPOSO;
      desp_q    <= '0;
      acc_q     <= 1'b0;
      cnt_q     <= '0;
      sel_q     <= 1'b0;
      paridad_q <= 1'b0;
      origen_q  <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      desp_q    <= desp_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      paridad_q <= paridad_d;
      origen_q  <= origen_d;
    end
  end

  assign bus.Concedido = concedido;
  assign bus.Ocupado   = (estado_q != REPOSO);
  assign bus.Listo     = (estado_q == FIN) && !Reinicio;
  assign bus.Paridad   = paridad_q;
  assign bus.Origen    = origen_q;

endmodule

`default_nettype wire

// File: doc/paridad_serial_arbitrada.md
PARIDAD_SERIAL_ARBITRADA -- requirements
Module: paridad_serial_arbitrada

Interface
REQ-001 Parameter ANCHO, default 8, data word width in bits; SHALL be even and >= 2.
REQ-002 Reloj  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Reinicio  input  1  reset; SHALL be synchronous and active-high.
REQ-004 Solicitud  input  2  per-requester request level; bit i is held high until Concedido[i] pulses.
REQ-005 Dato0  input  ANCHO  word from requester 0; sampled only in the grant cycle.
REQ-006 Dato1  input  ANCHO  word from requester 1; sampled only in the grant cycle.
REQ-007 Concedido  output  2  one-hot, one-cycle acceptance pulse; marks the cycle the word is captured.
REQ-008 Ocupado  output  1  high whenever the FSM is not in REPOSO.
REQ-009 Listo  output  1  one-cycle pulse; Paridad and Origen are valid in that cycle.
REQ-010 Paridad  output  1  XOR reduction of the accepted word; held until the next Listo.
REQ-011 Origen  output  1  index of the requester that owns Paridad; held with Paridad.

Function
REQ-012 FSM states SHALL be REPOSO, CALCULO and FIN.
REQ-013 REPOSO, any Solicitud high: grant one requester, pulse its Concedido bit, load its Dato into a shift register, clear the accumulator and step counter, go to CALCULO.
REQ-014 REPOSO, no Solicitud high: stay; Concedido = 0.
REQ-015 Arbitration SHALL be round-robin with a 1-bit priority pointer: the pointed requester wins a tie; after each grant the pointer moves to the non-granted requester.
REQ-016 A single requester SHALL be granted regardless of the pointer.
REQ-017 CALCULO: each cycle, accumulator <= accumulator XOR (bit1 XOR bit0) of the shift register's two LSBs; register shifts right by 2; counter increments.
REQ-018 CALCULO SHALL last exactly ANCHO/2 cycles, then go to FIN.
REQ-019 FIN: Listo = 1 for one cycle; Paridad <= final accumulator and Origen <= granted index are registered visible in that cycle; next state REPOSO.
REQ-020 Latency: grant in cycle t SHALL yield Listo in cycle t+ANCHO/2+1; no grant in FIN; next grant no earlier than t+ANCHO/2+2.
REQ-021 Solicitud changes and Dato changes outside the grant cycle SHALL be ignored in CALCULO and FIN.
REQ-022 Concedido and Listo SHALL never be high in the same cycle.

Reset
REQ-023 Reinicio high SHALL force, at the next edge: state REPOSO, pointer = 0, Concedido = 00, Ocupado = 0, Listo = 0, Paridad = 0, Origen = 0, accumulator, counter and shift register = 0.
REQ-024 Reinicio during CALCULO or FIN SHALL abort the operation with no Listo pulse; the aborted request is not retried automatically.
REQ-025 Reinicio SHALL take priority over every other input in the same cycle.

Structure
REQ-026 A shared package SHALL hold the state encoding (REPOSO, CALCULO, FIN) and the requester-count constant (2).
REQ-027 Arbitration (pointer plus grant logic) SHALL be a sub-module named arbitro_rr; the datapath and FSM stay in the top.

Verification
REQ-028 After reset, Solicitud=01, Dato0=8'hA5 -> Concedido=01 for one cycle; Listo 5 cycles later with Paridad=0, Origen=0.
REQ-029 Solicitud=10, Dato1=8'h07 -> Concedido=10; Listo with Paridad=1, Origen=1; Ocupado high from the cycle after the grant through Listo.
REQ-030 After reset, Solicitud=11 held -> grants alternate 01,10,01 with Listo for each; first Origen=0.
REQ-031 Reinicio pulse two cycles after a grant -> no Listo; Ocupado=0 and Paridad=0 after the edge; the next Solicitud=10 is granted with pointer 0 semantics.
REQ-032 Dato0 changed from 8'h01 to 8'hFF during CALCULO -> Paridad=1 (captured value used).
REQ-033 ANCHO=2, Dato0=2'b11 -> Listo 2 cycles after grant, Paridad=0.
